// File: rtl/cpu_pkg.sv
// Shared CPU types for the writeback stage.
// Retirement entry layout and writeback source selects.
package cpu_pkg;

  localparam int WB_DW = 32;
  localparam int WB_RW = 4;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef struct packed {
    logic             reg_wr;
    logic             wb_sel;
    logic [WB_RW-1:0] reg_dst;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order retirement FIFO of wb_entry_t.
// Head entry is read combinationally; push/pop are ignored when full/empty.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  wb_entry_t     i_data,
  input  logic          i_pop,
  output wb_entry_t     o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);

  wb_entry_t         r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE;
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: in-order retirement with variable-latency load data.
// Drives the register-file write port that also feeds decode bypass.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int RW    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_reg_wr,
  input  logic                     in_wb_sel,
  input  logic [RW-1:0]            in_reg_dst,
  input  logic [DW-1:0]            in_alu_result,
  input  logic                     mem_rdata_valid,
  output logic                     mem_rdata_ready,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     wr,
  output logic [RW-1:0]            wr_dst,
  output logic [DW-1:0]            wr_data,
  output logic                     stall_out,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_orphan
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            r_hold_valid;
  logic [DW-1:0]   r_hold_data;
  logic [CW-1:0]   r_load_pend;
  logic            r_wr;
  logic [RW-1:0]   r_wr_dst;
  logic [DW-1:0]   r_wr_data;
  logic            r_err;

  wb_entry_t       w_in;
  wb_entry_t       w_head;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic            w_push;
  logic            w_pop;
  logic            w_mem_acc;
  logic            w_orphan;
  logic            w_mem_use;
  logic            w_head_ld;
  logic            w_hold_cap;
  logic            w_hold_clr;
  logic            w_ld_push;
  logic [DW-1:0]   w_data;

  assign w_in = '{
    reg_wr:  in_reg_wr,
    wb_sel:  in_wb_sel,
    reg_dst: in_reg_dst,
    data:    in_alu_result
  };

  wb_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign in_ready        = !w_full;
  assign stall_out       = w_full;
  assign occupancy       = w_count;
  assign mem_rdata_ready = !r_hold_valid;
  assign wr              = r_wr;
  assign wr_dst          = r_wr_dst;
  assign wr_data         = r_wr_data;
  assign err_orphan      = r_err;

  assign w_push    = in_valid && in_ready;
  assign w_ld_push = w_push && (in_wb_sel == WB_SEL_MEM);
  assign w_mem_acc = mem_rdata_valid && mem_rdata_ready;
  assign w_orphan  = w_mem_acc && (r_load_pend == '0);
  assign w_mem_use = w_mem_acc && !w_orphan;
  assign w_head_ld = !w_empty && (w_head.wb_sel == WB_SEL_MEM);

  assign w_pop = !w_empty &&
                 (!w_head_ld || r_hold_valid || w_mem_use);

  // Data consumed straight from memory never lands in hold
  assign w_hold_clr = w_pop && w_head_ld && r_hold_valid;
  assign w_hold_cap = w_mem_use && !(w_pop && w_head_ld);

  always_comb begin
    w_data = w_head.data;
    unique case (1'b1)
      !w_head_ld:                 w_data = w_head.data;
      w_head_ld && r_hold_valid:  w_data = r_hold_data;
      w_head_ld && !r_hold_valid: w_data = mem_rdata;
      default:                    w_data = w_head.data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_load_pend  <= '0;
      r_wr         <= 1'b0;
      r_wr_dst     <= '0;
      r_wr_data    <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_hold_cap) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= mem_rdata;
      end else if (w_hold_clr) begin
        r_hold_valid <= 1'b0;
      end
      r_load_pend <= r_load_pend + CW'(w_ld_push)
                     - CW'(w_mem_use);
      r_wr <= w_pop && w_head.reg_wr;
      if (w_pop) begin
        r_wr_dst  <= w_head.reg_dst;
        r_wr_data <= w_data;
      end
      if (w_orphan) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: queue-based retirement model checked every cycle,
// plus directed scenarios with literal expected writes.
module tb_wb_stage;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int RW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_reg_wr = 1'b0;
  logic          in_wb_sel = 1'b0;
  logic [RW-1:0] in_reg_dst = '0;
  logic [DW-1:0] in_alu_result = '0;
  logic          mem_rdata_valid = 1'b0;
  logic          mem_rdata_ready;
  logic [DW-1:0] mem_rdata = '0;
  logic          wr;
  logic [RW-1:0] wr_dst;
  logic [DW-1:0] wr_data;
  logic          stall_out;
  logic [$clog2(DEPTH):0] occupancy;
  logic          err_orphan;

  int checks = 0;
  int failures = 0;

  wb_stage #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_reg_wr       (in_reg_wr),
    .in_wb_sel       (in_wb_sel),
    .in_reg_dst      (in_reg_dst),
    .in_alu_result   (in_alu_result),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata_ready (mem_rdata_ready),
    .mem_rdata       (mem_rdata),
    .wr              (wr),
    .wr_dst          (wr_dst),
    .wr_data         (wr_data),
    .stall_out       (stall_out),
    .occupancy       (occupancy),
    .err_orphan      (err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        reg_wr;
    bit        wb_sel;
    bit [3:0]  dst;
    bit [31:0] val;
  } ent_t;

  ent_t      mq[$];
  bit [31:0] dq[$];
  int        pend;
  bit        m_err;
  bit        m_wr;
  bit [3:0]  m_dst;
  bit [31:0] m_data;
  bit        m_live = 1'b0;

  // Model: instructions queue, early load data queue (one slot)
  always @(posedge clk) begin : model
    bit rdy_in, rdy_mem, acc, orph, took, ret;
    ent_t h;
    bit [31:0] d;
    if (!rst_n) begin
      mq.delete();
      dq.delete();
      pend = 0;
      m_err = 1'b0;
      m_wr = 1'b0;
      m_dst = '0;
      m_data = '0;
      m_live = 1'b1;
    end else if (m_live) begin
      rdy_in  = mq.size() < DEPTH;
      rdy_mem = dq.size() == 0;
      acc  = mem_rdata_valid && rdy_mem;
      orph = acc && (pend == 0);
      took = 1'b0;
      ret  = 1'b0;
      d    = '0;
      h    = '{1'b0, 1'b0, 4'h0, 32'h0};
      if (mq.size() > 0) begin
        h = mq[0];
        if (!h.wb_sel) begin
          ret = 1'b1;
          d = h.val;
        end else if (dq.size() > 0) begin
          ret = 1'b1;
          d = dq.pop_front();
        end else if (acc && !orph) begin
          ret = 1'b1;
          d = mem_rdata;
          took = 1'b1;
        end
      end
      if (acc && !orph && !took) dq.push_back(mem_rdata);
      if (acc && !orph) pend--;
      if (orph) m_err = 1'b1;
      m_wr = ret && h.reg_wr;
      if (ret) begin
        m_dst = h.dst;
        m_data = d;
        void'(mq.pop_front());
      end
      if (in_valid && rdy_in) begin
        mq.push_back('{in_reg_wr, in_wb_sel, in_reg_dst, in_alu_result});
        if (in_wb_sel) pend++;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit ok;
    if (m_live) begin
      ok = (in_ready == (mq.size() < DEPTH)) &&
           (stall_out == !(mq.size() < DEPTH)) &&
           (int'(occupancy) == mq.size()) &&
           (mem_rdata_ready == (dq.size() == 0)) &&
           (wr == m_wr) && (wr_dst == m_dst) &&
           (wr_data == m_data) && (err_orphan == m_err);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL model_cmp t=%0t act rdy=%b stall=%b occ=%0d mrdy=%b wr=%b dst=%0d data=%h err=%b exp rdy=%b occ=%0d mrdy=%b wr=%b dst=%0d data=%h err=%b",
                 $time, in_ready, stall_out, occupancy, mem_rdata_ready,
                 wr, wr_dst, wr_data, err_orphan,
                 mq.size() < DEPTH, mq.size(), dq.size() == 0,
                 m_wr, m_dst, m_data, m_err);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit rw, input bit sel, input logic [3:0] dst,
                      input logic [31:0] val);
    in_valid = 1'b1;
    in_reg_wr = rw;
    in_wb_sel = sel;
    in_reg_dst = dst;
    in_alu_result = val;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic mem(input logic [31:0] v);
    mem_rdata_valid = 1'b1;
    mem_rdata = v;
    cyc();
    mem_rdata_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    @(negedge clk);
    lit("rst_occ", 32'(occupancy), 0);
    lit("rst_wr", 32'(wr), 0);
    lit("rst_rdy", 32'(in_ready), 1);
    lit("rst_err", 32'(err_orphan), 0);

    // ALU stream
    push(1, 0, 4'd3, 32'h11);
    push(1, 0, 4'd5, 32'h22);
    @(negedge clk);
    lit("alu0_wr", 32'(wr), 1);
    lit("alu0_dst", 32'(wr_dst), 3);
    lit("alu0_data", wr_data, 32'h11);
    @(negedge clk);
    lit("alu1_wr", 32'(wr), 1);
    lit("alu1_dst", 32'(wr_dst), 5);
    lit("alu1_data", wr_data, 32'h22);
    @(negedge clk);
    lit("alu_idle_wr", 32'(wr), 0);

    // Load waiting at head
    push(1, 1, 4'd7, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      lit("ld_wait_wr", 32'(wr), 0);
    end
    mem(32'hDEADBEEF);
    @(negedge clk);
    lit("ld_wr", 32'(wr), 1);
    lit("ld_dst", 32'(wr_dst), 7);
    lit("ld_data", wr_data, 32'hDEADBEEF);

    // Early load data behind an ALU head goes into hold
    push(1, 1, 4'd9, 32'h0);
    push(1, 0, 4'd1, 32'h5);
    push(1, 1, 4'd2, 32'h0);
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'h99;
    cyc();
    mem_rdata = 32'hAA;
    cyc();
    mem_rdata_valid = 1'b0;
    @(negedge clk);
    lit("early_mrdy", 32'(mem_rdata_ready), 0);
    lit("early_dst0", 32'(wr_dst), 1);
    lit("early_data0", wr_data, 32'h5);
    @(negedge clk);
    lit("early_wr1", 32'(wr), 1);
    lit("early_dst1", 32'(wr_dst), 2);
    lit("early_data1", wr_data, 32'hAA);
    lit("early_mrdy1", 32'(mem_rdata_ready), 1);

    // Fill behind a blocked load
    push(1, 1, 4'd4, 32'h0);
    push(1, 0, 4'd10, 32'h10);
    push(1, 0, 4'd11, 32'h11);
    push(1, 0, 4'd12, 32'h12);
    in_valid = 1'b1;
    in_reg_wr = 1'b1;
    in_wb_sel = 1'b0;
    in_reg_dst = 4'd13;
    in_alu_result = 32'h13;
    @(negedge clk);
    lit("full_occ", 32'(occupancy), 4);
    lit("full_rdy", 32'(in_ready), 0);
    lit("full_stall", 32'(stall_out), 1);
    mem(32'h44);
    @(negedge clk);
    lit("drain_rdy", 32'(in_ready), 1);
    lit("drain_occ", 32'(occupancy), 3);
    lit("drain_dst4", 32'(wr_dst), 4);
    lit("drain_data4", wr_data, 32'h44);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lit("drain_wr", 32'(wr), 1);
      lit("drain_dst", 32'(wr_dst), 32'(10 + i));
    end
    @(negedge clk);
    lit("drain_end_wr", 32'(wr), 0);
    lit("drain_end_occ", 32'(occupancy), 0);

    // Orphan data, then a non-writing store
    mem(32'h77);
    @(negedge clk);
    lit("orphan_err", 32'(err_orphan), 1);
    lit("orphan_occ", 32'(occupancy), 0);
    push(0, 0, 4'd6, 32'h66);
    @(negedge clk);
    lit("store_occ1", 32'(occupancy), 1);
    @(negedge clk);
    lit("store_wr", 32'(wr), 0);
    lit("store_occ0", 32'(occupancy), 0);
    lit("store_dst", 32'(wr_dst), 6);
    @(negedge clk);
    lit("orphan_sticky", 32'(err_orphan), 1);

    // Reset with loads in flight
    push(1, 1, 4'd1, 32'h0);
    push(1, 1, 4'd2, 32'h0);
    push(1, 1, 4'd3, 32'h0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    lit("mrst_occ", 32'(occupancy), 0);
    lit("mrst_wr", 32'(wr), 0);
    lit("mrst_err", 32'(err_orphan), 0);
    push(1, 0, 4'd8, 32'h88);
    @(negedge clk);
    lit("post_wr0", 32'(wr), 0);
    @(negedge clk);
    lit("post_wr1", 32'(wr), 1);
    lit("post_dst", 32'(wr_dst), 8);
    lit("post_data", wr_data, 32'h88);

    repeat (3) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
